psum_drain: RTL and testbench
=============================

PSUM_DRAIN -- requirements
Module: psum_drain

Interface
- REQ-001 Parameter col, default 8: number of psum elements per captured vector.
- REQ-002 Parameter bw_psum, default 20: width of one signed psum element.
- REQ-003 Parameter depth, default 4: number of vector entries in the FIFO (power of two, >=2).
- REQ-004 clk  input  1: single clock; all state updates on the rising edge.
- REQ-005 reset  input  1: asynchronous, active-low reset.
- REQ-006 psum_in  input  bw_psum*col: psum vector from the core output; element k occupies bits [bw_psum*(k+1)-1 : bw_psum*k].
- REQ-007 psum_valid  input  1: psum_in is valid this cycle.
- REQ-008 psum_ready  output  1: FIFO can accept a vector; equal to !full.
- REQ-009 dout  output  bw_psum: current serialized element.
- REQ-010 dout_valid  output  1: dout is valid; equal to !empty.
- REQ-011 dout_ready  input  1: downstream accepts dout this cycle.
- REQ-012 dout_idx  output  clog2(col): element index of dout within its vector.
- REQ-013 dout_last  output  1: high when dout_valid is high and dout_idx == col-1.
- REQ-014 full  output  1: entry count == depth.
- REQ-015 empty  output  1: entry count == 0.
- REQ-016 overflow  output  1: sticky flag, set when a vector is dropped.

Function
- REQ-017 Push: on a rising edge with psum_valid && !full, the block shall write psum_in to the tail entry and advance the write pointer modulo depth.
- REQ-018 Drop: on a rising edge with psum_valid && full, the block shall discard psum_in and set overflow, even if a pop occurs on the same edge.
- REQ-019 Transfer: an element is transferred on a rising edge with dout_valid && dout_ready; dout_valid shall not depend on dout_ready.
- REQ-020 On a transfer with dout_idx < col-1, the block shall increment dout_idx and keep the head entry.
- REQ-021 On a transfer with dout_idx == col-1, the block shall pop the head entry, advance the read pointer modulo depth, and return dout_idx to 0.
- REQ-022 dout shall be driven combinationally from head entry element dout_idx, with element 0 first.
- REQ-023 Latency: a vector pushed at edge N into an empty FIFO shall present element 0 with dout_valid=1 in the cycle after edge N.
- REQ-024 A simultaneous push and pop shall leave the count unchanged and shall be legal whenever the FIFO is not full.
- REQ-025 Pointer wrap from depth-1 to 0 shall be seamless and shall preserve FIFO order.
- REQ-026 While dout_valid && !dout_ready, dout, dout_idx and dout_last shall remain stable.
- REQ-027 The count register shall hold values 0..depth, and full and empty shall be derived from it.

Reset
- REQ-028 While reset=0, the block shall clear the pointers, count, dout_idx and overflow. Outputs: psum_ready=1, dout_valid=0, dout_last=0, dout_idx=0, full=0, empty=1, overflow=0. dout content is don't-care.
- REQ-029 Reset asserted mid-operation shall discard all stored vectors and any partially drained vector immediately. The FIFO storage array need not be reset.
- REQ-030 The first push shall be accepted on the first rising edge after reset deasserts.

Configuration
- REQ-031 Macro PSUM_DRAIN_RELU_EN: when defined, dout shall be 0 for any element whose sign bit is set, and the element value otherwise. When not defined, dout shall pass the stored two's-complement element unchanged. Storage, handshake and timing are identical in both builds.

Verification
- REQ-032 Reset, then push one vector with element k = k+1 and hold dout_ready=1: dout must show 1..8 on 8 consecutive cycles, dout_last=1 only on value 8, and empty=1 afterwards.
- REQ-033 Push 4 vectors with dout_ready=0: full=1 and psum_ready=0. Push a 5th vector: overflow=1 and the 5th vector never appears on dout.
- REQ-034 Toggle dout_ready 1/0 each cycle while pushing every 8th cycle for 20 vectors: all 160 elements must arrive in order with no loss, and pointers must wrap several times.
- REQ-035 Push element 0 = 20'hFFFFB (-5) with element 1 = 7: dout must be -5 then 7 without the macro, and 0 then 7 with PSUM_DRAIN_RELU_EN.
- REQ-036 Assert reset=0 after 3 elements of a vector have drained with 2 vectors queued: empty=1, dout_valid=0, overflow=0 immediately. After release, push a new vector: element 0 of the new vector must appear next.

Source files
------------

// File: rtl/psum_drain.sv
// Captures whole psum vectors into a small FIFO and drains them one element per transfer.
// Define PSUM_DRAIN_RELU_EN to clamp negative elements to zero on dout.
module psum_drain #(
    parameter int col     = 8,
    parameter int bw_psum = 20,
    parameter int depth   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [bw_psum*col-1:0]   psum_in,
    input  logic                     psum_valid,
    output logic                     psum_ready,
    output logic [bw_psum-1:0]       dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(col)-1:0]   dout_idx,
    output logic                     dout_last,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int IW = $clog2(col);
    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(col - 1);

    logic [col-1:0][bw_psum-1:0] r_mem [depth];
    logic [PW-1:0]               r_wptr;
    logic [PW-1:0]               r_rptr;
    logic [CW-1:0]               r_count;
    logic [IW-1:0]               r_idx;
    logic                        r_overflow;

    logic                        w_push;
    logic                        w_xfer;
    logic                        w_pop;
    logic [bw_psum-1:0]          w_elem;

    assign full       = (r_count == CW'(depth));
    assign empty      = (r_count == '0);
    assign psum_ready = !full;
    assign dout_valid = !empty;
    assign dout_idx   = r_idx;
    assign dout_last  = dout_valid && (r_idx == LAST_IDX);
    assign overflow   = r_overflow;

    // A vector offered while full is dropped even if the head pops on the same edge.
    assign w_push = psum_valid && !full;
    assign w_xfer = dout_valid && dout_ready;
    assign w_pop  = w_xfer && (r_idx == LAST_IDX);

    assign w_elem = r_mem[r_rptr][r_idx];

`ifdef PSUM_DRAIN_RELU_EN
    assign dout = w_elem[bw_psum-1] ? '0 : w_elem;
`else
    assign dout = w_elem;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= psum_in;
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (psum_valid && full) begin
                r_overflow <= 1'b1;
            end
            if (w_xfer) begin
                if (w_pop) begin
                    r_idx  <= '0;
                    r_rptr <= r_rptr + PW'(1);
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed self-checking bench for psum_drain with default parameters.
// Expected values are hand-derived from the vector bases pushed in each step.
module tb_psum_drain;

    localparam int COL   = 8;
    localparam int BW    = 20;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [BW*COL-1:0] psum_in;
    logic              psum_valid;
    logic              psum_ready;
    logic [BW-1:0]     dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [2:0]        dout_idx;
    logic              dout_last;
    logic              full;
    logic              empty;
    logic              overflow;

    int checks = 0;
    int fails  = 0;

    psum_drain #(.col(COL), .bw_psum(BW), .depth(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_idx   (dout_idx),
        .dout_last  (dout_last),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [BW*COL-1:0] vec, input logic valid, input logic rdy);
        psum_in    = vec;
        psum_valid = valid;
        dout_ready = rdy;
    endtask

    function automatic logic [BW*COL-1:0] mkVec(input int base);
        logic [BW*COL-1:0] v;
        for (int k = 0; k < COL; k++) begin
            v[k*BW +: BW] = BW'(base + k);
        end
        return v;
    endfunction

    initial begin
        logic [BW*COL-1:0] sv;
        int                cyc;
        int                nextVec;
        int                rcv;

        reset = 1'b0;
        applyStimulus('0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("rst_psum_ready", 32'(psum_ready), 32'd1);
        checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
        checkOutput("rst_dout_last",  32'(dout_last),  32'd0);
        checkOutput("rst_dout_idx",   32'(dout_idx),   32'd0);
        checkOutput("rst_full",       32'(full),       32'd0);
        checkOutput("rst_empty",      32'(empty),      32'd1);
        checkOutput("rst_overflow",   32'(overflow),   32'd0);

        $display("[TB] single vector drain");
        reset = 1'b1;
        applyStimulus(mkVec(1), 1'b1, 1'b1);
        tick();
        psum_valid = 1'b0;
        checkOutput("lat_dout_valid", 32'(dout_valid), 32'd1);
        for (int k = 0; k < COL; k++) begin
            checkOutput("single_dout", 32'(dout),      32'(k + 1));
            checkOutput("single_last", 32'(dout_last), 32'(k == COL - 1));
            checkOutput("single_idx",  32'(dout_idx),  32'(k));
            tick();
        end
        checkOutput("single_empty", 32'(empty),      32'd1);
        checkOutput("single_valid", 32'(dout_valid), 32'd0);

        $display("[TB] fill, overflow and drop during pop");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(mkVec(32'h100 + 16*i), 1'b1, 1'b0);
            tick();
        end
        psum_valid = 1'b0;
        checkOutput("fill_full",       32'(full),       32'd1);
        checkOutput("fill_psum_ready", 32'(psum_ready), 32'd0);
        checkOutput("fill_overflow",   32'(overflow),   32'd0);
        applyStimulus(mkVec(32'hAAA00), 1'b1, 1'b0);
        tick();
        psum_valid = 1'b0;
        checkOutput("drop_overflow", 32'(overflow), 32'd1);
        checkOutput("drop_full",     32'(full),     32'd1);
        for (int e = 0; e < DEPTH*COL; e++) begin
            applyStimulus(mkVec(32'hBBB00), (e == COL - 1), 1'b1);
            checkOutput("drain_dout", 32'(dout), 32'(32'h100 + 16*(e/COL) + (e%COL)));
            tick();
        end
        psum_valid = 1'b0;
        checkOutput("drain_empty",    32'(empty),    32'd1);
        checkOutput("drain_overflow", 32'(overflow), 32'd1);

        $display("[TB] stall and mid-operation reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mkVec(32'h200 + 16*i), 1'b1, 1'b0);
            tick();
        end
        applyStimulus('0, 1'b0, 1'b1);
        repeat (3) tick();
        dout_ready = 1'b0;
        tick();
        tick();
        checkOutput("stall_dout", 32'(dout),      32'h203);
        checkOutput("stall_idx",  32'(dout_idx),  32'd3);
        checkOutput("stall_last", 32'(dout_last), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("mrst_empty",      32'(empty),      32'd1);
        checkOutput("mrst_dout_valid", 32'(dout_valid), 32'd0);
        checkOutput("mrst_overflow",   32'(overflow),   32'd0);
        checkOutput("mrst_idx",        32'(dout_idx),   32'd0);
        checkOutput("mrst_psum_ready", 32'(psum_ready), 32'd1);
        tick();
        reset = 1'b1;
        applyStimulus(mkVec(32'h500), 1'b1, 1'b0);
        tick();
        psum_valid = 1'b0;
        checkOutput("post_rst_valid", 32'(dout_valid), 32'd1);
        checkOutput("post_rst_dout",  32'(dout),       32'h500);
        checkOutput("post_rst_idx",   32'(dout_idx),   32'd0);
        dout_ready = 1'b1;
        repeat (COL) tick();
        checkOutput("post_rst_empty", 32'(empty), 32'd1);

        $display("[TB] signed element handling");
        sv = '0;
        sv[BW-1:0]    = 20'hFFFFB;
        sv[2*BW-1:BW] = 20'd7;
        applyStimulus(sv, 1'b1, 1'b1);
        tick();
        psum_valid = 1'b0;
`ifdef PSUM_DRAIN_RELU_EN
        checkOutput("neg_elem", 32'(dout), 32'h0);
`else
        checkOutput("neg_elem", 32'(dout), 32'hFFFFB);
`endif
        tick();
        checkOutput("pos_elem", 32'(dout), 32'd7);
        repeat (COL - 1) tick();
        checkOutput("signed_empty", 32'(empty), 32'd1);

        $display("[TB] toggled ready with periodic pushes");
        cyc     = 0;
        nextVec = 0;
        rcv     = 0;
        dout_ready = 1'b0;
        while (rcv < 20*COL && cyc < 3000) begin
            dout_ready = ~dout_ready;
            psum_in    = mkVec(32'h3000 + 16*nextVec);
            psum_valid = (nextVec < 20) && (cyc >= 8*nextVec) && psum_ready;
            if (dout_valid && dout_ready) begin
                checkOutput("sb_dout", 32'(dout), 32'(32'h3000 + 16*(rcv/COL) + (rcv%COL)));
                checkOutput("sb_idx",  32'(dout_idx), 32'(rcv % COL));
                rcv++;
            end
            if (psum_valid) begin
                nextVec++;
            end
            tick();
            cyc++;
        end
        psum_valid = 1'b0;
        checkOutput("sb_count",    32'(rcv),      32'(20*COL));
        checkOutput("sb_empty",    32'(empty),    32'd1);
        checkOutput("sb_overflow", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
